// File: rtl/commutator_stream.sv
// Output commutator for the polyphase interpolator: takes a parallel frame of N
// signed samples and serialises it CW or CCW with a start-phase rotation.
module commutator_stream #(
  parameter int gp_idata_width = 26,
  parameter int gp_nr_channels = 32,
  parameter int gp_phase       = 0
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_ena,
  input  logic                                     i_ccw,
  input  logic                                     i_valid,
  input  logic [gp_nr_channels*gp_idata_width-1:0] i_data,
  output logic                                     o_ready,
  output logic signed [gp_idata_width-1:0]         o_data,
  output logic                                     o_valid,
  output logic [$clog2(gp_nr_channels)-1:0]        o_chan,
  output logic                                     o_first,
  output logic                                     o_last,
  output logic                                     o_clk
);

  localparam int N  = gp_nr_channels;
  localparam int W  = gp_idata_width;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] PH    = CW'(gp_phase);
  localparam logic [CW-1:0] LASTC = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic signed [W-1:0] frame_in [N];
  logic signed [W-1:0] hold_p0  [N];
  logic                hold_ccw_p0;
  logic                hold_full_p0;

  logic signed [W-1:0] act_p1 [N];
  logic                act_ccw_p1;
  state_t              state_p1;
  logic [CW-1:0]       cnt_p1;
  logic [CW-1:0]       idx_p1;
  logic [CW-1:0]       ch_p1;

  logic signed [W-1:0] data_p2;
  logic                vld_p2;
  logic [CW-1:0]       chan_p2;
  logic                first_p2;
  logic                last_p2;
  logic                clk_p2;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      frame_in[k] = $signed(i_data[k*W +: W]);
    end
  end

  // idx is a wrap counter preloaded with the phase, so it is already (cnt+phase) mod N
  assign ch_p1   = act_ccw_p1 ? idx_p1 : (LASTC - idx_p1);
  assign o_ready = !hold_full_p0 && i_ena && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N; k++) begin
        hold_p0[k] <= '0;
        act_p1[k]  <= '0;
      end
      hold_ccw_p0  <= 1'b0;
      hold_full_p0 <= 1'b0;
      act_ccw_p1   <= 1'b0;
      state_p1     <= IDLE;
      cnt_p1       <= '0;
      idx_p1       <= '0;
      data_p2      <= '0;
      vld_p2       <= 1'b0;
      chan_p2      <= '0;
      first_p2     <= 1'b0;
      last_p2      <= 1'b0;
      clk_p2       <= 1'b0;
    end else if (i_ena) begin
      // stage p0: hold register capture
      if (i_valid && !hold_full_p0) begin
        hold_p0      <= frame_in;
        hold_ccw_p0  <= i_ccw;
        hold_full_p0 <= 1'b1;
      end
      clk_p2 <= last_p2;
      // stage p1 -> p2: active frame sequencing and registered outputs
      case (state_p1)
        IDLE: begin
          vld_p2   <= 1'b0;
          data_p2  <= '0;
          chan_p2  <= '0;
          first_p2 <= 1'b0;
          last_p2  <= 1'b0;
          if (hold_full_p0) begin
            act_p1       <= hold_p0;
            act_ccw_p1   <= hold_ccw_p0;
            hold_full_p0 <= 1'b0;
            cnt_p1       <= '0;
            idx_p1       <= PH;
            state_p1     <= RUN;
          end
        end
        RUN: begin
          vld_p2   <= 1'b1;
          data_p2  <= act_p1[ch_p1];
          chan_p2  <= ch_p1;
          first_p2 <= (cnt_p1 == '0);
          last_p2  <= (cnt_p1 == LASTC);
          if (cnt_p1 == LASTC) begin
            if (hold_full_p0) begin
              act_p1       <= hold_p0;
              act_ccw_p1   <= hold_ccw_p0;
              hold_full_p0 <= 1'b0;
              cnt_p1       <= '0;
              idx_p1       <= PH;
            end else begin
              state_p1 <= IDLE;
            end
          end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
            idx_p1 <= (idx_p1 == LASTC) ? '0 : idx_p1 + 1'b1;
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign o_data  = data_p2;
  assign o_valid = vld_p2;
  assign o_chan  = chan_p2;
  assign o_first = first_p2;
  assign o_last  = last_p2;
  assign o_clk   = clk_p2;

endmodule

// File: tb/tb_commutator_stream.sv
// Scoreboard bench for commutator_stream with N=4, W=8; a phase-0 and a phase-1
// instance share the same stimulus.
module tb_commutator_stream;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst, ena, ccw, valid;
  logic [N*W-1:0] data;
  logic          ready0, ready1;
  logic [W-1:0]  odata0, odata1;
  logic          ovalid0, ovalid1;
  logic [1:0]    ochan0, ochan1;
  logic          ofirst0, ofirst1, olast0, olast1, oclk0, oclk1;

  always #5 clk = ~clk;

  commutator_stream #(.gp_idata_width(W), .gp_nr_channels(N), .gp_phase(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ccw(ccw), .i_valid(valid), .i_data(data),
    .o_ready(ready0), .o_data(odata0), .o_valid(ovalid0), .o_chan(ochan0),
    .o_first(ofirst0), .o_last(olast0), .o_clk(oclk0));

  commutator_stream #(.gp_idata_width(W), .gp_nr_channels(N), .gp_phase(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ccw(ccw), .i_valid(valid), .i_data(data),
    .o_ready(ready1), .o_data(odata1), .o_valid(ovalid1), .o_chan(ochan1),
    .o_first(ofirst1), .o_last(olast1), .o_clk(oclk1));

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   ch;
    logic         first;
    logic         last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] FA = 32'h44332211;
  localparam logic [31:0] FB = 32'h88776655;
  localparam logic [31:0] FC = 32'hCCBBAA99;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] frame, input int k, input bit dir, input int ph);
    exp_t e;
    int idx, ch;
    idx = (k + ph) % N;
    ch  = dir ? idx : N - 1 - idx;
    e.d     = frame[ch*W +: W];
    e.ch    = 2'(ch);
    e.first = (k == 0);
    e.last  = (k == N - 1);
    return e;
  endfunction

  task automatic send(input logic [31:0] frame, input bit dir);
    bit rdy;
    int n;
    data  = frame;
    ccw   = dir;
    valid = 1'b1;
    n     = 0;
    do begin
      @(negedge clk);
      rdy = ready0;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    #1;
    if (!rdy) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < N; k++) begin
        q0.push_back(mk(frame, k, dir, 0));
        q1.push_back(mk(frame, k, dir, 1));
      end
      check("ready_after_accept", {31'd0, ready0}, 32'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_queues_empty", q0.size() + q1.size(), 32'd0);
  endtask

  // Monitor: the enable/reset seen at the edge just passed was the value held at the previous negedge
  bit ena_seen = 1'b0;
  bit rst_seen = 1'b1;
  logic prev_last = 1'b0;
  logic [W+1:0] prev_pack = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      check("reset_outputs", {22'd0, ovalid0, odata0, oclk0}, 32'd0);
    end else if (ena_seen) begin
      check("o_clk", {31'd0, oclk0}, {31'd0, prev_last});
      if (ovalid0) begin
        if (q0.size() == 0) begin
          check("unexpected_valid0", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          check("data0", {24'd0, odata0}, {24'd0, e.d});
          check("chan_first_last0", {28'd0, ochan0, ofirst0, olast0}, {28'd0, e.ch, e.first, e.last});
        end
      end else begin
        check("idle_data0", {24'd0, odata0}, 32'd0);
      end
      if (ovalid1) begin
        if (q1.size() == 0) begin
          check("unexpected_valid1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          check("data_chan1", {22'd0, odata1, ochan1}, {22'd0, e.d, e.ch});
        end
      end
    end else begin
      check("held_outputs", {22'd0, ovalid0, odata0, oclk0}, {22'd0, prev_pack});
    end
    if (!ena || rst) check("ready_low", {30'd0, ready0, ready1}, 32'd0);
    prev_last = olast0;
    prev_pack = {ovalid0, odata0, oclk0};
    ena_seen  = ena;
    rst_seen  = rst;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; ccw = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready0}, 32'd0);
    check("reset_state", {27'd0, ovalid0, ochan0, ofirst0, olast0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, ready0}, 32'd1);

    // single frames: CCW then CW
    send(FA, 1'b1); valid = 1'b0; drain();
    send(FA, 1'b0); valid = 1'b0; drain();

    // two frames back-to-back
    send(FA, 1'b1); send(FB, 1'b1); valid = 1'b0; drain();

    // three frames, direction changes while earlier frames are in flight
    send(FA, 1'b1); send(FB, 1'b0); send(FC, 1'b1); valid = 1'b0; drain();

    // enable toggling during RUN
    send(FB, 1'b1); valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      ena = (i % 2 == 1);
    end
    ena = 1'b1;
    drain();

    // reset at sample 2 of A with B waiting in hold
    send(FA, 1'b1); send(FB, 1'b1); valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q0.delete(); q1.delete();
    check("rst_mid_valid_data", {23'd0, ovalid0, odata0}, 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(FC, 1'b0); valid = 1'b0; drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
